// File: rtl/if_fetch_unit.sv
// Instruction-fetch sequencer: one outstanding instruction-memory request at a time,
// delivers fetched words into the IF/ID register and holds the PC until delivery or redirect.
module if_fetch_unit #(
    parameter int               XLEN      = 32,
    parameter logic [XLEN-1:0]  NOP_INSTR = 32'h00000013
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [XLEN-1:0]  pc_f,
    input  logic             stall_d,
    input  logic             flush,
    output logic             imem_req_valid,
    input  logic             imem_req_ready,
    output logic [XLEN-1:0]  imem_req_addr,
    input  logic             imem_rsp_valid,
    input  logic [XLEN-1:0]  imem_rsp_data,
    output logic             stall_f,
    output logic [XLEN-1:0]  instr_d,
    output logic [XLEN-1:0]  pc_d,
    output logic             valid_d,
    output logic [1:0]       state_dbg
);

    // Handshake: a request transfers on the cycle imem_req_valid && imem_req_ready are both
    // high; once valid is raised the address is held until that cycle. Memory returns exactly
    // one single-cycle imem_rsp_valid per transferred request, on a later cycle.

    typedef enum logic [1:0] {
        ST_ISSUE = 2'd0,
        ST_WAIT  = 2'd1,
        ST_HOLD  = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic              pend_q, pend_d;
    logic              drop_q, drop_d;
    logic [XLEN-1:0]   addr_q, addr_d;
    logic [XLEN-1:0]   tag_q, tag_d;
    logic [XLEN-1:0]   buf_q, buf_d;
    logic [XLEN-1:0]   ifid_instr_q, ifid_instr_d;
    logic [XLEN-1:0]   ifid_pc_q, ifid_pc_d;
    logic              ifid_valid_q, ifid_valid_d;
    logic              deliver;
    logic [XLEN-1:0]   deliver_data;

    always_comb begin
        state_d        = state_q;
        pend_d         = pend_q;
        drop_d         = drop_q;
        addr_d         = addr_q;
        tag_d          = tag_q;
        buf_d          = buf_q;
        imem_req_valid = 1'b0;
        imem_req_addr  = pend_q ? addr_q : pc_f;
        deliver        = 1'b0;
        deliver_data   = buf_q;

        case (state_q)
            ST_ISSUE: begin
                imem_req_valid = 1'b1;
                // A flush before acceptance still lets the stale request go out; its word is dropped.
                drop_d = drop_q | flush;
                if (imem_req_ready) begin
                    tag_d   = imem_req_addr;
                    pend_d  = 1'b0;
                    state_d = ST_WAIT;
                end else begin
                    pend_d = 1'b1;
                    addr_d = imem_req_addr;
                end
            end
            ST_WAIT: begin
                if (imem_rsp_valid) begin
                    if (drop_q || flush) begin
                        drop_d  = 1'b0;
                        state_d = ST_ISSUE;
                    end else if (stall_d) begin
                        buf_d   = imem_rsp_data;
                        state_d = ST_HOLD;
                    end else begin
                        deliver      = 1'b1;
                        deliver_data = imem_rsp_data;
                        state_d      = ST_ISSUE;
                    end
                end else if (flush) begin
                    drop_d = 1'b1;
                end
            end
            ST_HOLD: begin
                if (flush) begin
                    state_d = ST_ISSUE;
                end else if (!stall_d) begin
                    deliver = 1'b1;
                    state_d = ST_ISSUE;
                end
            end
            default: state_d = ST_ISSUE;
        endcase

        ifid_instr_d = ifid_instr_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_valid_d = ifid_valid_q;
        if (flush) begin
            ifid_valid_d = 1'b0;
            ifid_instr_d = NOP_INSTR;
        end else if (deliver) begin
            ifid_valid_d = 1'b1;
            ifid_instr_d = deliver_data;
            ifid_pc_d    = tag_q;
        end else if (!stall_d) begin
            ifid_valid_d = 1'b0;
            ifid_instr_d = NOP_INSTR;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_ISSUE;
            pend_q       <= 1'b0;
            drop_q       <= 1'b0;
            addr_q       <= '0;
            tag_q        <= '0;
            buf_q        <= '0;
            ifid_instr_q <= NOP_INSTR;
            ifid_pc_q    <= '0;
            ifid_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pend_q       <= pend_d;
            drop_q       <= drop_d;
            addr_q       <= addr_d;
            tag_q        <= tag_d;
            buf_q        <= buf_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_valid_q <= ifid_valid_d;
        end
    end

    // The PC register advances on delivery and loads the redirect target on any flush.
    assign stall_f   = !(deliver || flush);
    assign instr_d   = ifid_instr_q;
    assign pc_d      = ifid_pc_q;
    assign valid_d   = ifid_valid_q;
    assign state_dbg = state_q;

endmodule
